// File: rtl/sonar_echo_timer.sv
// Ultrasonic ranging engine: fires a trigger pulse, then times the returned echo with a timeout.
// Optional SONAR_AVG_EN reports a 4-sample moving average of valid measurements.
module sonar_echo_timer #(
   parameter int unsigned TRIG_CYCLES    = 500,
   parameter int unsigned TIMEOUT_CYCLES = 1900000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        echo_in,
   output logic        trig_out,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic        timed_out,
   output logic [31:0] echo_cycles
);

   localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE
   } state_t;

   state_t      r_state;
   logic        r_echo_m;
   logic        r_echo_s;
   logic        r_echo_prev;
   logic [31:0] r_trig_cnt;
   logic [31:0] r_timeout_cnt;
   logic [31:0] r_width_cnt;
   logic        r_trig_out;
   logic        r_done;
   logic        r_valid;
   logic        r_timed_out;
   logic [31:0] r_echo_cycles;

   logic        w_rise;
   logic        w_fall;
   logic        w_timeout;
   logic [31:0] w_width_next;
   logic [31:0] w_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_echo_m    <= 1'b0;
         r_echo_s    <= 1'b0;
         r_echo_prev <= 1'b0;
      end else begin
         r_echo_m    <= echo_in;
         r_echo_s    <= r_echo_m;
         r_echo_prev <= r_echo_s;
      end
   end

   assign w_rise    = r_echo_s & ~r_echo_prev;
   assign w_fall    = ~r_echo_s & r_echo_prev;
   assign w_timeout = (r_timeout_cnt == TIMEOUT_LAST);

   // Width counter saturates instead of wrapping.
   assign w_width_next = (r_echo_s && (r_width_cnt != '1)) ? r_width_cnt + 32'd1 : r_width_cnt;

`ifdef SONAR_AVG_EN
   logic [31:0] r_avg_buf [4];
   logic        r_avg_primed;
   logic [33:0] w_avg_sum;

   // The first valid sample is replicated into all four slots, so its average is itself.
   always_comb begin
      w_avg_sum = {r_width_cnt, 2'b00};
      if (r_avg_primed) begin
         w_avg_sum = 34'(r_width_cnt) + 34'(r_avg_buf[0]) + 34'(r_avg_buf[1]) + 34'(r_avg_buf[2]);
      end
   end

   assign w_result = w_avg_sum[33:2];

   // NOTE: the buffer is reset on purpose, a restart must not average against stale results.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) r_avg_buf[i] <= '0;
         r_avg_primed <= 1'b0;
      end else if (r_state == S_MEASURE && w_fall) begin
         r_avg_primed <= 1'b1;
         if (!r_avg_primed) begin
            for (int i = 0; i < 4; i++) r_avg_buf[i] <= r_width_cnt;
         end else begin
            r_avg_buf[3] <= r_avg_buf[2];
            r_avg_buf[2] <= r_avg_buf[1];
            r_avg_buf[1] <= r_avg_buf[0];
            r_avg_buf[0] <= r_width_cnt;
         end
      end
   end
`else
   assign w_result = r_width_cnt;
`endif

   // NOTE: all state and outputs update with non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_trig_cnt    <= '0;
         r_timeout_cnt <= '0;
         r_width_cnt   <= '0;
         r_trig_out    <= 1'b0;
         r_done        <= 1'b0;
         r_valid       <= 1'b0;
         r_timed_out   <= 1'b0;
         r_echo_cycles <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_TRIG;
                  r_trig_out <= 1'b1;
                  r_trig_cnt <= '0;
               end
            end
            S_TRIG: begin
               if (r_trig_cnt == TRIG_LAST) begin
                  r_state       <= S_WAIT_RISE;
                  r_trig_out    <= 1'b0;
                  r_timeout_cnt <= '0;
               end else begin
                  r_trig_cnt <= r_trig_cnt + 32'd1;
               end
            end
            S_WAIT_RISE: begin
               r_timeout_cnt <= r_timeout_cnt + 32'd1;
               if (w_timeout) begin
                  r_state     <= S_IDLE;
                  r_valid     <= 1'b0;
                  r_timed_out <= 1'b1;
                  r_done      <= 1'b1;
               end else if (w_rise) begin
                  // The rise cycle already has echo_s high, so it counts as the first cycle.
                  r_state     <= S_MEASURE;
                  r_width_cnt <= 32'd1;
               end
            end
            S_MEASURE: begin
               r_timeout_cnt <= r_timeout_cnt + 32'd1;
               r_width_cnt   <= w_width_next;
               if (w_fall) begin
                  r_state       <= S_IDLE;
                  r_echo_cycles <= w_result;
                  r_valid       <= 1'b1;
                  r_timed_out   <= 1'b0;
                  r_done        <= 1'b1;
               end else if (w_timeout) begin
                  r_state     <= S_IDLE;
                  r_valid     <= 1'b0;
                  r_timed_out <= 1'b1;
                  r_done      <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign trig_out    = r_trig_out;
   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign valid       = r_valid;
   assign timed_out   = r_timed_out;
   assign echo_cycles = r_echo_cycles;

endmodule

// File: tb/tb_sonar_echo_timer.sv
// Directed bench for sonar_echo_timer (TRIG_CYCLES=4, TIMEOUT_CYCLES=100); table of echo scenarios
// plus hand-written reset sequences. Expected echo_cycles also follows SONAR_AVG_EN when defined.
module tb_sonar_echo_timer;

   localparam int TRIG    = 4;
   localparam int TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        echo_in;
   logic        trig_out;
   logic        busy;
   logic        done;
   logic        valid;
   logic        timed_out;
   logic [31:0] echo_cycles;

   int n_checks = 0;
   int n_errors = 0;

   sonar_echo_timer #(
      .TRIG_CYCLES   (TRIG),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .echo_in    (echo_in),
      .trig_out   (trig_out),
      .busy       (busy),
      .done       (done),
      .valid      (valid),
      .timed_out  (timed_out),
      .echo_cycles(echo_cycles)
   );

   always #5 clk = ~clk;

   // pre: echo already high before start, dropping pre cycles after WAIT_RISE entry (0 = none).
   // dly/w: echo_in high for w cycles starting dly cycles after WAIT_RISE entry (w = 0: no echo).
   // done_at: cycles from WAIT_RISE entry to the done pulse.
   typedef struct {
      int pre;
      int dly;
      int w;
      int done_at;
      bit ok;
   } vec_t;

   vec_t vecs [13];

   logic [31:0] m_buf [4];
   bit          m_primed;
   logic [31:0] m_exp_cycles;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_buf[i] = '0;
      m_primed     = 1'b0;
      m_exp_cycles = '0;
   endtask

   task automatic model_valid(input logic [31:0] m);
`ifdef SONAR_AVG_EN
      logic [33:0] sum;
      if (!m_primed) begin
         for (int i = 0; i < 4; i++) m_buf[i] = m;
         m_primed = 1'b1;
      end else begin
         m_buf[3] = m_buf[2];
         m_buf[2] = m_buf[1];
         m_buf[1] = m_buf[0];
         m_buf[0] = m;
      end
      sum = 34'(m_buf[0]) + 34'(m_buf[1]) + 34'(m_buf[2]) + 34'(m_buf[3]);
      m_exp_cycles = sum[33:2];
`else
      m_exp_cycles = m;
`endif
   endtask

   task automatic wait_trig_low(output int cnt);
      int guard = 0;
      cnt = 0;
      while (trig_out === 1'b1 && guard < 50) begin
         cnt++;
         start = (cnt == 2);
         tick();
         guard++;
      end
      start = 1'b0;
   endtask

   task automatic measure(input int idx, input vec_t v);
      int trig_cnt;
      int trig_late = 0;
      int done_at   = -1;
      echo_in = (v.pre > 0);
      start   = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("done_not_consecutive[%0d]", idx), 32'(done), 32'd0);
      check($sformatf("busy_in_trig[%0d]", idx), 32'(busy), 32'd1);
      wait_trig_low(trig_cnt);
      check($sformatf("trig_width[%0d]", idx), 32'(trig_cnt), 32'(TRIG));
      for (int k = 0; k < 400; k++) begin
         echo_in = (k < v.pre) || (k >= v.dly && k < v.dly + v.w);
         start   = (k == 3);
         tick();
         if (trig_out) trig_late++;
         if (done) begin
            done_at = k + 1;
            break;
         end
      end
      echo_in = 1'b0;
      start   = 1'b0;
      if (v.ok) model_valid(32'(v.w));
      check($sformatf("done_at[%0d]", idx), 32'(done_at), 32'(v.done_at));
      check($sformatf("no_retrigger[%0d]", idx), 32'(trig_late), 32'd0);
      check($sformatf("busy_at_done[%0d]", idx), 32'(busy), 32'd0);
      check($sformatf("valid[%0d]", idx), 32'(valid), 32'(v.ok));
      check($sformatf("timed_out[%0d]", idx), 32'(timed_out), 32'(!v.ok));
      check($sformatf("echo_cycles[%0d]", idx), echo_cycles, m_exp_cycles);
   endtask

   task automatic reset_mid_op();
      int trig_cnt;
      int dones = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_trig_low(trig_cnt);
      for (int k = 0; k < 16; k++) begin
         echo_in = (k >= 2);
         tick();
      end
      check("busy_before_reset", 32'(busy), 32'd1);
      reset   = 1'b1;
      echo_in = 1'b0;
      tick();
      model_reset();
      check("rst_mid_trig_out", 32'(trig_out), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      check("rst_mid_valid", 32'(valid), 32'd0);
      check("rst_mid_timed_out", 32'(timed_out), 32'd0);
      check("rst_mid_echo_cycles", echo_cycles, m_exp_cycles);
      reset = 1'b0;
      for (int k = 0; k < 150; k++) begin
         tick();
         if (done || busy) dones++;
      end
      check("rst_mid_quiet", 32'(dones), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{pre: 0,  dly: 10, w: 37,  done_at: 50,  ok: 1'b1};
      vecs[1]  = '{pre: 0,  dly: 0,  w: 0,   done_at: 100, ok: 1'b0};
      vecs[2]  = '{pre: 0,  dly: 10, w: 300, done_at: 100, ok: 1'b0};
      vecs[3]  = '{pre: 0,  dly: 2,  w: 1,   done_at: 6,   ok: 1'b1};
      vecs[4]  = '{pre: 0,  dly: 0,  w: 5,   done_at: 8,   ok: 1'b1};
      vecs[5]  = '{pre: 0,  dly: 20, w: 77,  done_at: 100, ok: 1'b1};
      vecs[6]  = '{pre: 0,  dly: 20, w: 76,  done_at: 99,  ok: 1'b1};
      vecs[7]  = '{pre: 30, dly: 35, w: 12,  done_at: 50,  ok: 1'b1};
      vecs[8]  = '{pre: 0,  dly: 5,  w: 40,  done_at: 48,  ok: 1'b1};
      vecs[9]  = '{pre: 0,  dly: 0,  w: 0,   done_at: 100, ok: 1'b0};
      vecs[10] = '{pre: 0,  dly: 5,  w: 80,  done_at: 88,  ok: 1'b1};
      vecs[11] = '{pre: 0,  dly: 5,  w: 80,  done_at: 88,  ok: 1'b1};
      vecs[12] = '{pre: 0,  dly: 5,  w: 80,  done_at: 88,  ok: 1'b1};

      model_reset();
      reset   = 1'b1;
      start   = 1'b0;
      echo_in = 1'b0;
      repeat (3) tick();
      check("rst_trig_out", 32'(trig_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_timed_out", 32'(timed_out), 32'd0);
      check("rst_echo_cycles", echo_cycles, 32'd0);
      reset = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 13; i++) begin
         if (i == 8) reset_mid_op();
         measure(i, vecs[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
